alu_arbiter: RTL and testbench

- Shares one ALU instance among N_REQ requesters, such as per-core or per-channel sequencers.
- Arbitrates with a round-robin policy and issues one operation per cycle, fully pipelined.
- Drives the ALU's operand inputs and its late `ctrl` input, which is needed because the ALU registers its operands internally and decodes `ctrl` combinationally one cycle later.
- Captures the ALU result and returns it to the originating requester with a one-hot valid.

---
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU (registered operands, late combinational ctrl) among N_REQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round robin.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [3*N_REQ-1:0]          req_ctrl,
    input  logic [DATA_WIDTH*N_REQ-1:0] req_in0,
    input  logic [DATA_WIDTH*N_REQ-1:0] req_in1,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic [DATA_WIDTH-1:0]       alu_in0,
    output logic [DATA_WIDTH-1:0]       alu_in1,
    output logic [2:0]                  alu_ctrl,
    input  logic [DATA_WIDTH-1:0]       alu_out
);

    localparam logic [2:0] CTRL_NOP = 3'd7;

    if (N_REQ < 2 || N_REQ > 16 || ID_WIDTH != $clog2(N_REQ)) begin : g_bad_cfg
        $error("alu_arbiter: inconsistent N_REQ / ID_WIDTH");
    end

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [N_REQ-1:0]      gnt;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic                  gnt_found;
    logic                  fire;

    logic [DATA_WIDTH-1:0] sel_in0;
    logic [DATA_WIDTH-1:0] sel_in1;
    logic [2:0]            sel_ctrl;

    logic [DATA_WIDTH-1:0] alu_in0_q, alu_in0_d;
    logic [DATA_WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [2:0]            alu_ctrl_q, alu_ctrl_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [2:0]            s1_ctrl_q, s1_ctrl_d;
    logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
    logic [N_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr = rr_ptr_q;

    // Wrap on N_REQ, not 2^ID_WIDTH, so odd requester counts rotate correctly.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            if (int'(gnt_id) + 1 >= N_REQ) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_id + ID_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_found && !hold && !reset) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    assign fire = |gnt;

    always_comb begin
        sel_in0  = req_in0[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
        sel_in1  = req_in1[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
        sel_ctrl = req_ctrl[int'(gnt_id)*3 +: 3];
    end

    // Operands hold across bubbles; the NOP ctrl keeps the ALU output at zero.
    always_comb begin
        alu_in0_d  = alu_in0_q;
        alu_in1_d  = alu_in1_q;
        if (fire) begin
            alu_in0_d = sel_in0;
            alu_in1_d = sel_in1;
        end
        s1_valid_d = fire;
        s1_ctrl_d  = fire ? sel_ctrl : CTRL_NOP;
        s1_id_d    = gnt_id;
        s2_valid_d = s1_valid_q;
        s2_id_d    = s1_id_q;
        alu_ctrl_d = s1_valid_q ? s1_ctrl_q : CTRL_NOP;
        resp_data_d = alu_out;
    end

    always_comb begin
        resp_valid_d = '0;
        if (s2_valid_q) begin
            resp_valid_d[s2_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_in0_q    <= '0;
            alu_in1_q    <= '0;
            alu_ctrl_q   <= CTRL_NOP;
            s1_valid_q   <= 1'b0;
            s1_ctrl_q    <= CTRL_NOP;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_id_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            alu_in0_q    <= alu_in0_d;
            alu_in1_q    <= alu_in1_d;
            alu_ctrl_q   <= alu_ctrl_d;
            s1_valid_q   <= s1_valid_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_id_q      <= s2_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = gnt;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign alu_in0    = alu_in0_q;
    assign alu_in1    = alu_in1_q;
    assign alu_ctrl   = alu_ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, corner sequences and randomized traffic for alu_arbiter,
// with a registered-operand ALU model attached to the ALU ports.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [3*N-1:0]  req_ctrl;
    logic [DW*N-1:0] req_in0;
    logic [DW*N-1:0] req_in1;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic [DW-1:0]   alu_in0;
    logic [DW-1:0]   alu_in1;
    logic [2:0]      alu_ctrl;
    logic [DW-1:0]   alu_out;
    logic [DW-1:0]   alu_a_q;
    logic [DW-1:0]   alu_b_q;

    alu_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_in0(req_in0), .req_in1(req_in1),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            3'd0: return a & b;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return {31'b0, a == b};
            3'd4: return {31'b0, $signed(a) < $signed(b)};
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // ALU: operands registered, ctrl decoded combinationally one cycle later
    always @(posedge clk) begin
        alu_a_q <= alu_in0;
        alu_b_q <= alu_in1;
    end
    assign alu_out = alu_ref(alu_ctrl, alu_a_q, alu_b_q);

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        int          rq;
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    op_t          q[N][$];
    int           nchk = 0;
    int           nerr = 0;
    int           cyc  = 0;
    int           ptr  = 0;
    logic [31:0]  exp_in0;
    logic [31:0]  exp_in1;
    logic [N-1:0] ring_rv[8];
    logic [31:0]  ring_rd[8];
    logic [2:0]   ring_c[8];
    logic         ring_cv[8];
    int           grants[$];
    logic [31:0]  resps[$];
    vec_t         tbl[10];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        ptr = 0;
        exp_in0 = '0;
        exp_in1 = '0;
        for (int i = 0; i < 8; i++) begin
            ring_rv[i] = '0;
            ring_rd[i] = '0;
            ring_c[i]  = 3'd7;
            ring_cv[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) q[i].delete();
    endtask

    // One clock: drive queue heads, predict grant, advance, check all outputs.
    task automatic step();
        logic [N-1:0] v;
        logic [N-1:0] eg;
        int gi;
        int s;
        op_t op;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                v[i] = 1'b1;
                req_ctrl[i*3 +: 3]  = q[i][0].c;
                req_in0[i*DW +: DW] = q[i][0].a;
                req_in1[i*DW +: DW] = q[i][0].b;
            end
        end
        req_valid = v;
        #1;
        eg = '0;
        gi = -1;
        if (!hold) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (gi < 0 && v[idx]) gi = idx;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(eg));
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) grants.push_back(i);
        end
        @(posedge clk);
        cyc++;
        if (gi >= 0) begin
            op = q[gi].pop_front();
            exp_in0 = op.a;
            exp_in1 = op.b;
            ring_c[(cyc + 1) % 8]  = op.c;
            ring_cv[(cyc + 1) % 8] = 1'b1;
            ring_rv[(cyc + 2) % 8] = eg;
            ring_rd[(cyc + 2) % 8] = alu_ref(op.c, op.a, op.b);
`ifdef ALU_ARB_FIXED_PRIO_EN
            ptr = 0;
`else
            ptr = (gi + 1) % N;
`endif
        end
        #1;
        s = cyc % 8;
        chk("alu_in0", alu_in0, exp_in0);
        chk("alu_in1", alu_in1, exp_in1);
        chk("alu_ctrl", 32'(alu_ctrl), ring_cv[s] ? 32'(ring_c[s]) : 32'd7);
        chk("resp_valid", 32'(resp_valid), 32'(ring_rv[s]));
        if (ring_rv[s] != '0) chk("resp_data", resp_data, ring_rd[s]);
        if (resp_valid != '0) resps.push_back(resp_data);
        ring_cv[s] = 1'b0;
        ring_rv[s] = '0;
        @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        hold = 1'b0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && budget < 200) begin
            step();
            budget++;
        end
        chk("drain_budget", 32'(budget < 200), 32'd1);
        repeat (4) step();
    endtask

    function automatic op_t mk(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        op_t o;
        o.c = c;
        o.a = a;
        o.b = b;
        return o;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom % 4)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n3;
        int base;
        int expg[5];
        logic [31:0] expd[5];

        tbl[0] = '{1, 3'd1, 32'd5, 32'd7, 32'd12};
        tbl[1] = '{2, 3'd4, 32'h8000_0000, 32'd1, 32'd1};
        tbl[2] = '{3, 3'd3, 32'd9, 32'd9, 32'd1};
        tbl[3] = '{0, 3'd7, 32'd3, 32'd4, 32'd0};
        tbl[4] = '{2, 3'd2, 32'd0, 32'd1, 32'hFFFF_FFFF};
        tbl[5] = '{1, 3'd6, 32'hF0, 32'hFF, 32'h0F};
        tbl[6] = '{0, 3'd0, 32'hF0F0, 32'hFF00, 32'hF000};
        tbl[7] = '{3, 3'd5, 32'hF0, 32'h0F, 32'hFF};
        tbl[8] = '{1, 3'd4, 32'd1, 32'h8000_0000, 32'd0};
        tbl[9] = '{2, 3'd3, 32'd5, 32'd6, 32'd0};

        reset = 1'b1;
        hold = 1'b0;
        req_valid = 4'b0001;
        req_ctrl = '0;
        req_in0 = '0;
        req_in1 = '0;
        clear_model();
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_alu_in0", alu_in0, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0;

        // round robin from pointer 0 with back-to-back ops
        for (int i = 0; i < N; i++) q[i].push_back(mk(3'd2, 32'(10 * i), 32'd1));
        q[0].push_back(mk(3'd2, 32'd0, 32'd1));
        grants.delete();
        resps.delete();
        drain();
`ifdef ALU_ARB_FIXED_PRIO_EN
        expg = '{0, 0, 1, 2, 3};
        expd = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd19, 32'd29};
`else
        expg = '{0, 1, 2, 3, 0};
        expd = '{32'hFFFF_FFFF, 32'd9, 32'd19, 32'd29, 32'hFFFF_FFFF};
`endif
        chk("rr_ngrant", 32'(grants.size()), 32'd5);
        chk("rr_nresp", 32'(resps.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) chk("rr_grant_order", 32'(grants[i]), 32'(expg[i]));
            if (i < resps.size()) chk("rr_resp_order", resps[i], expd[i]);
        end

        // directed single ops
        for (int t = 0; t < 10; t++) begin
            q[tbl[t].rq].push_back(mk(tbl[t].c, tbl[t].a, tbl[t].b));
            resps.delete();
            repeat (5) step();
            chk("tbl_nresp", 32'(resps.size()), 32'd1);
            if (resps.size() > 0) chk("tbl_data", resps[0], tbl[t].e);
        end

        // single requester: one grant per cycle
        for (int i = 0; i < 6; i++) q[2].push_back(mk(3'd1, 32'(i), 32'd100));
        grants.delete();
        repeat (6) step();
        chk("single_ngrant", 32'(grants.size()), 32'd6);
        drain();

        // hold with two ops in flight
        q[0].push_back(mk(3'd1, 32'd1, 32'd2));
        q[2].push_back(mk(3'd6, 32'hAA, 32'h55));
        step();
        step();
        q[3].push_back(mk(3'd1, 32'd40, 32'd2));
        q[1].push_back(mk(3'd2, 32'd50, 32'd8));
        hold = 1'b1;
        resps.delete();
        grants.delete();
        repeat (5) step();
        chk("hold_nresp", 32'(resps.size()), 32'd2);
        chk("hold_ngrant", 32'(grants.size()), 32'd0);
        chk("hold_alu_ctrl", 32'(alu_ctrl), 32'd7);
        drain();

        // requesters 0 and 3 streaming
        for (int i = 0; i < 6; i++) begin
            q[0].push_back(mk(3'd5, 32'(i), 32'h100));
            q[3].push_back(mk(3'd5, 32'(i), 32'h300));
        end
        grants.delete();
        repeat (6) step();
        n0 = 0;
        n3 = 0;
        foreach (grants[i]) begin
            if (grants[i] == 0) n0++;
            if (grants[i] == 3) n3++;
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("prio_n0", 32'(n0), 32'd6);
        chk("prio_n3", 32'(n3), 32'd0);
`else
        chk("rr2_n0", 32'(n0), 32'd3);
        chk("rr2_n3", 32'(n3), 32'd3);
`endif
        drain();

        // randomized traffic with random hold
        base = nerr;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() < 3 && ($urandom % 3) == 0)
                    q[i].push_back(mk(3'($urandom % 8), rnd_word(), rnd_word()));
            end
            hold = (($urandom % 8) == 0);
            step();
        end
        drain();
        chk("random_clean", 32'(nerr - base), 32'd0);

        // reset one cycle after a handshake
        q[1].push_back(mk(3'd1, 32'd100, 32'd23));
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp_data", resp_data, 32'd0);
        chk("mid_rst_alu_in0", alu_in0, 32'd0);
        chk("mid_rst_alu_in1", alu_in1, 32'd0);
        chk("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'd7);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        resps.delete();
        repeat (5) step();
        chk("mid_rst_no_resp", 32'(resps.size()), 32'd0);

        // pointer restarts at 0 after reset
        q[3].push_back(mk(3'd1, 32'd1, 32'd1));
        q[1].push_back(mk(3'd1, 32'd2, 32'd2));
        grants.delete();
        step();
        chk("post_rst_grant", 32'(grants.size() > 0 ? grants[0] : -1), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
